// File: rtl/frame_assembler_param_if.sv
// Bus bundle for the frame assembler: tick/arm inputs, sound and flight-table
// read ports, transmit-RAM write port and transmitter handshake.
interface frame_assembler_param_if #(
  parameter int DW     = 32,
  parameter int SA_W   = 9,
  parameter int PA_W   = 8,
  parameter int AW     = 10,
  parameter int FCNT_W = 4
) ();
  logic              timer;
  logic              msec;
  logic [SA_W-1:0]   snd_rd;
  logic [DW-1:0]     snd_data;
  logic [PA_W-1:0]   par_rd;
  logic [DW-1:0]     par_data;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              frame_rdy;
  logic [FCNT_W-1:0] frame_cnt;
  logic              tx_start;
  logic              tx_busy;
  logic              overrun;

  modport master (
    input  timer, msec, snd_data, par_data, tx_busy,
    output snd_rd, par_rd, wr_en, wr_addr, wr_data, frame_rdy, frame_cnt,
           tx_start, overrun
  );

  modport slave (
    output timer, msec, snd_data, par_data, tx_busy,
    input  snd_rd, par_rd, wr_en, wr_addr, wr_data, frame_rdy, frame_cnt,
           tx_start, overrun
  );
endinterface

// File: rtl/frame_assembler_param.sv
// Per-msec frame builder: copies sound words, a rolling window of flight
// parameters and an XOR checksum into transmit RAM, then kicks the transmitter.
module frame_assembler_param #(
  parameter int DW        = 32,
  parameter int SND_WORDS = 500,
  parameter int PAR_WORDS = 12,
  parameter int PAR_TOTAL = 190,
  parameter int SA_W      = 9,
  parameter int PA_W      = 8,
  parameter int AW        = 10,
  parameter int FCNT_W    = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  frame_assembler_param_if.master bus
);

  typedef enum logic [2:0] {IDLE, WAIT_FRAME, SND, PAR, CSUM, DONE} state_t;

  state_t            state, state_nxt;
  logic              msec_q, msec_edge;
  logic [SA_W-1:0]   snd_rd;
  logic [PA_W-1:0]   par_rd, par_cnt;
  logic [AW-1:0]     wr_addr, wcnt;
  logic [DW-1:0]     wr_data, csum, word;
  logic [FCNT_W-1:0] frame_cnt;
  logic              frame_rdy, overrun;
  // vld_pipe[0]: read issued last cycle (data now on the bus); vld_pipe[1]: write out
  logic [1:0]        vld_pipe;
  logic              src_par, src_csum;
  logic              start_frame, snd_issue, par_issue, csum_issue, tx_start, busy_st;
  logic              snd_last, par_last, par_wrap;

  assign msec_edge = bus.msec & ~msec_q;
  assign snd_last  = (snd_rd == SA_W'(SND_WORDS - 1));
  assign par_last  = (par_cnt == PA_W'(PAR_WORDS - 1));
  assign par_wrap  = (par_rd == PA_W'(PAR_TOTAL - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (bus.timer) state_nxt = WAIT_FRAME;
      WAIT_FRAME: if (msec_edge) state_nxt = SND;
      SND:        if (snd_last)  state_nxt = PAR;
      PAR:        if (par_last)  state_nxt = CSUM;
      CSUM:       state_nxt = DONE;
      DONE:       if (tx_start)  state_nxt = WAIT_FRAME;
      default:    state_nxt = IDLE;
    endcase
  end

  // DONE holds off tx_start until the checksum write has left the pipe
  always_comb begin
    start_frame = (state == WAIT_FRAME) && msec_edge;
    snd_issue   = (state == SND);
    par_issue   = (state == PAR);
    csum_issue  = (state == CSUM);
    busy_st     = (state == SND) || (state == PAR) || (state == CSUM) || (state == DONE);
    tx_start    = (state == DONE) && !vld_pipe[0] && !vld_pipe[1] && !bus.tx_busy;
  end

  // checksum tag enters one cycle after the last parameter read, so csum
  // already holds that word when the tag reaches the write stage
  assign word = src_csum ? csum : (src_par ? bus.par_data : bus.snd_data);

  always_ff @(posedge clock) begin
    if (reset) begin
      msec_q    <= 1'b0;
      frame_rdy <= 1'b0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
      snd_rd    <= '0;
      par_rd    <= '0;
      par_cnt   <= '0;
      vld_pipe  <= '0;
      src_par   <= 1'b0;
      src_csum  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wcnt      <= '0;
      csum      <= '0;
    end else begin
      msec_q    <= bus.msec;
      frame_rdy <= start_frame;
      vld_pipe  <= {vld_pipe[0], snd_issue | par_issue | csum_issue};
      src_par   <= par_issue;
      src_csum  <= csum_issue;
      if (msec_edge && busy_st) overrun <= 1'b1;
      if (start_frame) begin
        frame_cnt <= frame_cnt + FCNT_W'(1);
        snd_rd    <= '0;
      end
      if (snd_issue && !snd_last) snd_rd <= snd_rd + SA_W'(1);
      if (par_issue) begin
        par_rd  <= par_wrap ? '0 : par_rd + PA_W'(1);
        par_cnt <= par_last ? '0 : par_cnt + PA_W'(1);
      end
      if (vld_pipe[0]) begin
        wr_data <= word;
        wr_addr <= wcnt;
        wcnt    <= wcnt + AW'(1);
        csum    <= csum ^ word;
      end
      if (start_frame) begin
        wcnt <= '0;
        csum <= '0;
      end
    end
  end

  assign bus.snd_rd    = snd_rd;
  assign bus.par_rd    = par_rd;
  assign bus.wr_en     = vld_pipe[1];
  assign bus.wr_addr   = wr_addr;
  assign bus.wr_data   = wr_data;
  assign bus.frame_rdy = frame_rdy;
  assign bus.frame_cnt = frame_cnt;
  assign bus.tx_start  = tx_start;
  assign bus.overrun   = overrun;

endmodule

// File: tb/tb_frame_assembler_param.sv
// Randomized bench for frame_assembler_param against a frame-level reference
// model (expected word lists, parameter pointer, frame counter, sticky overrun).
module tb_frame_assembler_param;
  localparam int DW = 32, SNDW = 4, PARW = 2, PART = 3;
  localparam int SA_W = 9, PA_W = 8, AW = 10, FCNT_W = 4;
  localparam int FW = SNDW + PARW + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  frame_assembler_param_if #(.DW(DW), .SA_W(SA_W), .PA_W(PA_W), .AW(AW), .FCNT_W(FCNT_W)) bus ();

  frame_assembler_param #(
    .DW(DW), .SND_WORDS(SNDW), .PAR_WORDS(PARW), .PAR_TOTAL(PART),
    .SA_W(SA_W), .PA_W(PA_W), .AW(AW), .FCNT_W(FCNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [DW-1:0] snd_mem[SNDW];
  logic [DW-1:0] par_mem[PART];

  // synchronous stores: data follows the address by one clock
  always @(posedge clock) begin
    bus.snd_data <= (bus.snd_rd < SA_W'(SNDW)) ? snd_mem[bus.snd_rd[1:0]] : '0;
    bus.par_data <= (bus.par_rd < PA_W'(PART)) ? par_mem[bus.par_rd[1:0]] : '0;
  end

  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int wc_q[$], fr_q[$], tx_q[$];

  int n_chk = 0, n_fail = 0;
  int par_ptr = 0, fcnt_m = 0;
  bit ovr_m = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (bus.wr_en) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
      wc_q.push_back(cyc);
    end
    if (bus.frame_rdy) fr_q.push_back(cyc);
    if (bus.tx_start) begin
      tx_q.push_back(cyc);
      chk("tx_while_busy", 64'(bus.tx_busy), 64'd0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); fr_q.delete(); tx_q.delete();
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_snd_rd"},    64'(bus.snd_rd), 64'd0);
    chk({pfx, "_par_rd"},    64'(bus.par_rd), 64'd0);
    chk({pfx, "_wr_addr"},   64'(bus.wr_addr), 64'd0);
    chk({pfx, "_wr_data"},   64'(bus.wr_data), 64'd0);
    chk({pfx, "_frame_cnt"}, 64'(bus.frame_cnt), 64'd0);
    chk({pfx, "_wr_en"},     64'(bus.wr_en), 64'd0);
    chk({pfx, "_frame_rdy"}, 64'(bus.frame_rdy), 64'd0);
    chk({pfx, "_tx_start"},  64'(bus.tx_start), 64'd0);
    chk({pfx, "_overrun"},   64'(bus.overrun), 64'd0);
  endtask

  task automatic rand_mem();
    for (int i = 0; i < SNDW; i++) snd_mem[i] = $urandom;
    for (int i = 0; i < PART; i++) par_mem[i] = $urandom;
  endtask

  task automatic pulse_timer();
    step(); bus.timer = 1'b1;
    step(); bus.timer = 1'b0;
    step();
  endtask

  task automatic do_frame(input int busy, input bit ovr);
    logic [DW-1:0] exp[FW];
    logic [DW-1:0] x;
    int n, t_tx;
    x = '0;
    for (int i = 0; i < SNDW; i++) exp[i] = snd_mem[i];
    for (int j = 0; j < PARW; j++) exp[SNDW+j] = par_mem[(par_ptr + j) % PART];
    for (int i = 0; i < FW - 1; i++) x ^= exp[i];
    exp[FW-1] = x;
    par_ptr = (par_ptr + PARW) % PART;
    fcnt_m  = (fcnt_m + 1) % (1 << FCNT_W);
    if (ovr) ovr_m = 1'b1;
    clr();
    bus.tx_busy = (busy > 0);
    step(); n = cyc; bus.msec = 1'b1;
    step(); bus.msec = 1'b0;
    if (ovr) begin
      step(); bus.msec = 1'b1;
      step(); bus.msec = 1'b0;
    end
    for (int k = 0; k < 60 && wc_q.size() < FW; k++) step();
    chk("wr_count", 64'(wc_q.size()), 64'(FW));
    for (int i = 0; i < wc_q.size() && i < FW; i++) begin
      chk($sformatf("wr_addr[%0d]", i), 64'(wa_q[i]), 64'(i));
      chk($sformatf("wr_data[%0d]", i), 64'(wd_q[i]), 64'(exp[i]));
      chk($sformatf("wr_cyc[%0d]", i),  64'(wc_q[i]), 64'(n + 3 + i));
    end
    chk("frame_rdy_cnt", 64'(fr_q.size()), 64'd1);
    if (fr_q.size() > 0) chk("frame_rdy_cyc", 64'(fr_q[0]), 64'(n + 1));
    t_tx = n + FW + 3;
    if (busy > 0) begin
      repeat (busy) step();
      t_tx = cyc;
      bus.tx_busy = 1'b0;
    end
    for (int k = 0; k < 40 && tx_q.size() == 0; k++) step();
    repeat (3) step();
    chk("tx_count", 64'(tx_q.size()), 64'd1);
    if (tx_q.size() > 0) chk("tx_cyc", 64'(tx_q[0]), 64'(t_tx));
    chk("frame_cnt", 64'(bus.frame_cnt), 64'(fcnt_m));
    chk("overrun", 64'(bus.overrun), 64'(ovr_m));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    bus.timer = 1'b0; bus.msec = 1'b0; bus.tx_busy = 1'b0;
    for (int i = 0; i < SNDW; i++) snd_mem[i] = DW'(i + 'h10);
    for (int i = 0; i < PART; i++) par_mem[i] = DW'(i + 'h100);

    repeat (3) step();
    chk_zero("rst");
    reset = 1'b0;
    step();

    // msec ticks before arming produce nothing
    clr();
    repeat (3) begin
      step(); bus.msec = 1'b1;
      step(); bus.msec = 1'b0;
    end
    repeat (5) step();
    chk("idle_writes", 64'(wc_q.size()), 64'd0);
    chk("idle_frame_rdy", 64'(fr_q.size()), 64'd0);
    chk("idle_overrun", 64'(bus.overrun), 64'd0);

    pulse_timer();
    do_frame(0, 1'b0);
    do_frame(0, 1'b0);
    do_frame(0, 1'b0);
    do_frame(20, 1'b0);
    do_frame(0, 1'b1);
    for (int f = 5; f < 16; f++) begin
      rand_mem();
      repeat ($urandom_range(0, 3)) step();
      do_frame(($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 8)) : 0,
               ($urandom_range(0, 3) == 0));
    end
    chk("fcnt_wrap", 64'(bus.frame_cnt), 64'd0);

    // reset while the parameter words are being read
    rand_mem();
    clr();
    step(); n = cyc; bus.msec = 1'b1;
    step(); bus.msec = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();
    chk_zero("mrst");
    clr();
    reset = 1'b0;
    repeat (30) step();
    chk("mrst_writes", 64'(wc_q.size()), 64'd0);
    chk("mrst_tx", 64'(tx_q.size()), 64'd0);
    chk("mrst_cyc_sane", 64'(cyc > n + 30), 64'd1);
    step(); bus.msec = 1'b1;
    step(); bus.msec = 1'b0;
    repeat (5) step();
    chk("mrst_idle_frame_rdy", 64'(fr_q.size()), 64'd0);
    chk("mrst_idle_overrun", 64'(bus.overrun), 64'd0);

    par_ptr = 0; fcnt_m = 0; ovr_m = 1'b0;
    pulse_timer();
    do_frame(3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
